// File: rtl/init_mem_array.sv
// Self-initialising register file with enabled-cycle counter and result word; INITMEM_CHECKSUM_EN adds a running checksum.
// Latency: 1-cycle registered read, DEPTH-edge init sweep; no backpressure, strobes arriving during init are dropped.
module init_mem_array #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               INIT_BASE = 'h10,
  parameter int               INIT_STEP = 'h10,
  parameter int               CNT_W     = 32,
  parameter logic [WIDTH-1:0] MAGIC     = 'hAB,
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             reinit,
  input  logic             wr_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inc_valid,
  input  logic [AW-1:0]    inc_addr,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             ready,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] result
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_counter, w_counter_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             w_run;
  logic             w_init_we;
  logic             w_wr_we;
  logic             w_inc_we;
  logic [WIDTH-1:0] w_init_val;
  logic [WIDTH-1:0] w_inc_val;

  assign w_run      = (r_state == S_RUN);
  assign w_init_val = WIDTH'(INIT_BASE + int'(r_ptr) * INIT_STEP);
  assign w_init_we  = !w_run;
  assign w_wr_we    = w_run && !reinit && wr_valid;
  // A same-address write overrides the increment, so the increment is suppressed outright.
  assign w_inc_we   = w_run && !reinit && inc_valid && !(wr_valid && (wr_addr == inc_addr));
  assign w_inc_val  = r_mem[inc_addr] + WIDTH'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_counter_nxt = r_counter;
    case (r_state)
      S_INIT: begin
        w_ptr_nxt = r_ptr + AW'(1);
        if (r_ptr == AW'(DEPTH - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (reinit) begin
          w_state_nxt   = S_INIT;
          w_ptr_nxt     = '0;
          w_counter_nxt = '0;
        end else if (en) begin
          w_counter_nxt = r_counter + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_ptr     <= '0;
      r_counter <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_counter <= w_counter_nxt;
    end
  end

  // Storage is deliberately left out of reset; the sweep gives it known content.
  always_ff @(posedge clk) begin
    if (w_init_we) r_mem[r_ptr] <= w_init_val;
    if (w_inc_we)  r_mem[inc_addr] <= w_inc_val;
    if (w_wr_we)   r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

`ifdef INITMEM_CHECKSUM_EN
  logic [CNT_W-1:0] r_checksum, w_checksum_nxt;

  // Tracked as new-minus-old per updated entry; the sweep starts from a cleared sum.
  always_comb begin
    w_checksum_nxt = r_checksum;
    if (!w_run) begin
      w_checksum_nxt = r_checksum + CNT_W'(w_init_val);
    end else if (reinit) begin
      w_checksum_nxt = '0;
    end else begin
      if (w_wr_we) begin
        w_checksum_nxt = w_checksum_nxt + CNT_W'(wr_data) - CNT_W'(r_mem[wr_addr]);
      end
      if (w_inc_we) begin
        w_checksum_nxt = w_checksum_nxt + CNT_W'(w_inc_val) - CNT_W'(r_mem[inc_addr]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else begin
      r_checksum <= w_checksum_nxt;
    end
  end

  assign result = w_run ? (r_checksum + r_counter + CNT_W'(MAGIC)) : '0;
`else
  assign result = w_run ? (r_counter + CNT_W'(MAGIC)) : '0;
`endif

  assign rd_data = r_rd_data;
  assign ready   = w_run;
  assign counter = r_counter;

endmodule

// File: tb/tb_init_mem_array.sv
// Bench for init_mem_array at default parameters; expectations follow the INITMEM_CHECKSUM_EN setting.
module tb_init_mem_array;

`ifdef INITMEM_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam logic [31:0] EXP_INIT = CS ? 32'h14B : 32'hAB;
  localparam logic [31:0] EXP_CNT5 = CS ? 32'h150 : 32'hB0;
  localparam logic [31:0] EXP_WRFF = CS ? 32'h20F : 32'hB0;

  logic        clk = 1'b0;
  logic        rst_n, en, reinit, wr_valid, inc_valid;
  logic [1:0]  wr_addr, inc_addr, rd_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ready;
  logic [31:0] counter, result;

  init_mem_array dut (
    .clk(clk), .rst_n(rst_n), .en(en), .reinit(reinit),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .inc_valid(inc_valid), .inc_addr(inc_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .ready(ready), .counter(counter), .result(result)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  m_mem [4];
  bit          m_vld [4];
  bit          m_ready;
  int          m_ptr;
  logic [31:0] m_cnt;
  int          exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_result();
    logic [31:0] s;
    s = 32'h0;
    if (!m_ready) return 32'h0;
`ifdef INITMEM_CHECKSUM_EN
    for (int i = 0; i < 4; i++) s += 32'(m_mem[i]);
`endif
    return s + m_cnt + 32'hAB;
  endfunction

  // Called at a falling edge with inputs set; model advances, one rising edge, outputs checked.
  task automatic cycle();
    int e;
    exp_q.push_back(m_vld[rd_addr] ? int'(m_mem[rd_addr]) : -1);
    if (!m_ready) begin
      m_mem[m_ptr] = 8'(16 + m_ptr * 16);
      m_vld[m_ptr] = 1'b1;
      if (m_ptr == 3) m_ready = 1'b1;
      m_ptr = (m_ptr + 1) % 4;
    end else if (reinit) begin
      m_ready = 1'b0;
      m_ptr   = 0;
      m_cnt   = 32'h0;
    end else begin
      if (en) m_cnt = m_cnt + 32'h1;
      if (inc_valid) m_mem[inc_addr] = m_mem[inc_addr] + 8'h1;
      if (wr_valid) m_mem[wr_addr] = wr_data;
    end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e >= 0) check("rd_data", 32'(rd_data), 32'(e));
    check("ready", 32'(ready), 32'(m_ready));
    check("counter", counter, m_cnt);
    check("result", result, exp_result());
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    m_ptr   = 0;
    m_cnt   = 32'h0;
    exp_q.delete();
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_counter", counter, 32'h0);
    check("rst_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobes_off();
    en = 1'b0; reinit = 1'b0; wr_valid = 1'b0; inc_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_addr = 2'd0; wr_data = 8'h0; inc_addr = 2'd0; rd_addr = 2'd0;
    strobes_off();
    for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 4; i++) begin rd_addr = 2'(i); cycle(); end
    check("ready_after_init", 32'(ready), 32'h1);
    for (int i = 0; i < 4; i++) begin rd_addr = 2'(i); cycle(); end
    check("init_result", result, EXP_INIT);

    en = 1'b1;
    repeat (5) cycle();
    en = 1'b0;
    check("cnt5", counter, 32'd5);
    check("cnt5_result", result, EXP_CNT5);

    rd_addr = 2'd3; wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'hFF;
    cycle();
    check("wr_ff_result", result, EXP_WRFF);
    wr_valid = 1'b0; inc_valid = 1'b1; inc_addr = 2'd3;
    cycle();
    inc_valid = 1'b0;
    cycle();
    check("wrap_rd", 32'(rd_data), 32'h0);

    rd_addr = 2'd1; wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h55; inc_valid = 1'b1; inc_addr = 2'd1;
    cycle();
    strobes_off();
    cycle();
    check("collision_rd", 32'(rd_data), 32'h55);

    rd_addr = 2'd2; wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h55; inc_valid = 1'b1; inc_addr = 2'd2;
    cycle();
    strobes_off();
    cycle();
    check("split_rd2", 32'(rd_data), 32'h31);
    rd_addr = 2'd1;
    cycle();
    check("split_rd1", 32'(rd_data), 32'h55);

    reinit = 1'b1; en = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'h99;
    inc_valid = 1'b1; inc_addr = 2'd2;
    cycle();
    check("reinit_ready", 32'(ready), 32'h0);
    check("reinit_counter", counter, 32'h0);
    reinit = 1'b0;
    repeat (4) cycle();
    strobes_off();
    check("reinit_done_ready", 32'(ready), 32'h1);
    for (int i = 0; i < 4; i++) begin rd_addr = 2'(i); cycle(); end
    check("reinit_result", result, EXP_INIT);

    reinit = 1'b1;
    cycle();
    reinit = 1'b0;
    repeat (2) cycle();
    do_reset();
    repeat (3) cycle();
    check("sweep_not_done", 32'(ready), 32'h0);
    cycle();
    check("sweep_done", 32'(ready), 32'h1);
    check("final_result", result, EXP_INIT);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
